// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register bank: transaction states and byte-level constants.
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;
  localparam logic I2C_RW_READ = 1'b1;
  localparam logic [I2C_BYTE_W-1:0] I2C_RD_OOR = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PTR,
    ST_WR,
    ST_RD
  } i2c_state_e;

endpackage

// File: rtl/i2c_reg_pointer.sv
// Register pointer for the I2C register bank.
// Supports a full-byte load and an auto-increment that wraps at the last register.
module i2c_reg_pointer
  import i2c_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int AUTO_INC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [I2C_BYTE_W-1:0] load_val_i,
  input  logic                  advance_i,
  output logic [I2C_BYTE_W-1:0] ptr_o
);

  localparam logic [I2C_BYTE_W-1:0] LAST_IDX = I2C_BYTE_W'(NUM_REGS - 1);

  logic [I2C_BYTE_W-1:0] ptr_q, ptr_d;

  // An out-of-range pointer holds, so reads keep returning the filler byte.
  always_comb begin
    ptr_d = ptr_q;
    if (load_i) begin
      ptr_d = load_val_i;
    end else if (advance_i && (AUTO_INC != 0)) begin
      if (ptr_q < LAST_IDX) begin
        ptr_d = ptr_q + 1'b1;
      end else if (ptr_q == LAST_IDX) begin
        ptr_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/i2c_reg_bank.sv
// I2C-addressed register file behind the simple slave's strobe interface.
// Provides a pointer byte, auto-incrementing bursts, and read-only registers.
module i2c_reg_bank
  import i2c_pkg::*;
#(
  parameter int                        NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0]       RO_MASK    = '0,
  parameter logic [NUM_REGS*8-1:0]     RESET_VALS = '0,
  parameter int                        AUTO_INC   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [I2C_BYTE_W-1:0]     i2c_addr_rw,
  input  logic                      i2c_addr_rw_valid_stb,
  input  logic [I2C_BYTE_W-1:0]     i2c_data_rx,
  input  logic                      i2c_data_rx_valid_stb,
  output logic [I2C_BYTE_W-1:0]     i2c_data_tx,
  input  logic                      i2c_data_tx_loaded_stb,
  input  logic                      i2c_error_stb,
  input  logic [NUM_REGS*8-1:0]     regs_in,
  output logic [NUM_REGS*8-1:0]     regs_out,
  output logic [NUM_REGS-1:0]       reg_wr_stb,
  output logic [I2C_BYTE_W-1:0]     ptr
);

  i2c_state_e state_q, state_d;

  logic [I2C_BYTE_W-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS*8-1:0] regs_in_q;
  logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;
  logic [I2C_BYTE_W-1:0] tx_q, rd_val;
  logic [I2C_BYTE_W-1:0] ptr_cur;
  logic                  ptr_load, ptr_adv, wr_req;

  i2c_reg_pointer #(
    .NUM_REGS (NUM_REGS),
    .AUTO_INC (AUTO_INC)
  ) u_ptr (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ptr_load),
    .load_val_i (i2c_data_rx),
    .advance_i  (ptr_adv),
    .ptr_o      (ptr_cur)
  );

  // Error abort outranks everything; a new address byte outranks same-cycle data strobes.
  always_comb begin
    state_d  = state_q;
    ptr_load = 1'b0;
    ptr_adv  = 1'b0;
    wr_req   = 1'b0;
    if (i2c_error_stb) begin
      state_d = ST_IDLE;
    end else if (i2c_addr_rw_valid_stb) begin
      state_d = (i2c_addr_rw[0] == I2C_RW_READ) ? ST_RD : ST_PTR;
    end else begin
      unique case (state_q)
        ST_PTR: begin
          if (i2c_data_rx_valid_stb) begin
            ptr_load = 1'b1;
            state_d  = ST_WR;
          end
        end
        ST_WR: begin
          if (i2c_data_rx_valid_stb) begin
            wr_req  = 1'b1;
            ptr_adv = 1'b1;
          end
        end
        ST_RD: begin
          if (i2c_data_tx_loaded_stb) begin
            ptr_adv = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    wr_stb_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_stb_d[i] = wr_req && (ptr_cur == I2C_BYTE_W'(i)) && !RO_MASK[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RO_MASK[i] ? 8'h00 : RESET_VALS[i*8 +: 8];
      end
      wr_stb_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_stb_d[i]) begin
          regs_q[i] <= i2c_data_rx;
        end
      end
      wr_stb_q <= wr_stb_d;
    end
  end

  // Fabric inputs pass through one flop before reaching the read mux.
  always_ff @(posedge clk) begin
    regs_in_q <= regs_in;
  end

  always_comb begin
    rd_val = I2C_RD_OOR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ptr_cur == I2C_BYTE_W'(i)) begin
        rd_val = RO_MASK[i] ? regs_in_q[i*8 +: 8] : regs_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= RO_MASK[0] ? regs_in_q[7:0] : RESET_VALS[7:0];
    end else begin
      tx_q <= rd_val;
    end
  end

  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_out[i*8 +: 8] = RO_MASK[i] ? 8'h00 : regs_q[i];
    end
  end

  assign i2c_data_tx = tx_q;
  assign reg_wr_stb  = wr_stb_q;
  assign ptr         = ptr_cur;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// Bench for i2c_reg_bank: directed vector table, corner sequences, then random traffic
// compared against a transaction-level model of the register bank.
module tb_i2c_reg_bank;

  localparam int          NR = 8;
  localparam logic [7:0]  RO = 8'h40;
  localparam logic [63:0] RV = 64'h8070_6050_4030_2010;
  localparam int M_IDLE = 0, M_PTR = 1, M_WR = 2, M_RD = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i2c_addr_rw;
  logic        i2c_addr_rw_valid_stb;
  logic [7:0]  i2c_data_rx;
  logic        i2c_data_rx_valid_stb;
  logic [7:0]  i2c_data_tx;
  logic        i2c_data_tx_loaded_stb;
  logic        i2c_error_stb;
  logic [63:0] regs_in;
  logic [63:0] regs_out;
  logic [7:0]  reg_wr_stb;
  logic [7:0]  ptr;

  always #5 clk = ~clk;

  i2c_reg_bank #(
    .NUM_REGS   (NR),
    .RO_MASK    (RO),
    .RESET_VALS (RV),
    .AUTO_INC   (1)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .i2c_addr_rw            (i2c_addr_rw),
    .i2c_addr_rw_valid_stb  (i2c_addr_rw_valid_stb),
    .i2c_data_rx            (i2c_data_rx),
    .i2c_data_rx_valid_stb  (i2c_data_rx_valid_stb),
    .i2c_data_tx            (i2c_data_tx),
    .i2c_data_tx_loaded_stb (i2c_data_tx_loaded_stb),
    .i2c_error_stb          (i2c_error_stb),
    .regs_in                (regs_in),
    .regs_out               (regs_out),
    .reg_wr_stb             (reg_wr_stb),
    .ptr                    (ptr)
  );

  typedef enum int {OP_ADDR_W, OP_ADDR_R, OP_RX, OP_TXL, OP_ERR} op_e;

  typedef struct {
    op_e        op;
    logic [7:0] data;
    logic [7:0] expPtr;
    logic [7:0] expStb;
    logic [7:0] expTx;
  } vec_t;

  vec_t vecs[$];
  int nCompared = 0;
  int nMismatched = 0;

  logic [7:0] mRegs [NR];
  int mPtr;
  int mMode;

  function automatic void addVec(op_e op, logic [7:0] d, logic [7:0] p, logic [7:0] s, logic [7:0] t);
    vec_t v;
    v.op = op; v.data = d; v.expPtr = p; v.expStb = s; v.expTx = t;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one strobe for a single clock and returns at the next posedge+1.
  task automatic applyStimulus(input op_e op, input logic [7:0] data);
    case (op)
      OP_ADDR_W: begin i2c_addr_rw = 8'h84; i2c_addr_rw_valid_stb = 1'b1; end
      OP_ADDR_R: begin i2c_addr_rw = 8'h85; i2c_addr_rw_valid_stb = 1'b1; end
      OP_RX:     begin i2c_data_rx = data;  i2c_data_rx_valid_stb = 1'b1; end
      OP_TXL:    i2c_data_tx_loaded_stb = 1'b1;
      default:   i2c_error_stb = 1'b1;
    endcase
    @(posedge clk); #1;
    i2c_addr_rw_valid_stb  = 1'b0;
    i2c_data_rx_valid_stb  = 1'b0;
    i2c_data_tx_loaded_stb = 1'b0;
    i2c_error_stb          = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk); #1;
  endtask

  function automatic int nextPtr(int p);
    if (p < NR - 1) return p + 1;
    if (p == NR - 1) return 0;
    return p;
  endfunction

  function automatic logic [7:0] modelRead();
    if (mPtr >= NR) return 8'hFF;
    if (RO[mPtr]) return regs_in[mPtr*8 +: 8];
    return mRegs[mPtr];
  endfunction

  function automatic logic [63:0] modelRegsOut();
    logic [63:0] v = '0;
    for (int i = 0; i < NR; i++) v[i*8 +: 8] = RO[i] ? 8'h00 : mRegs[i];
    return v;
  endfunction

  function automatic logic [7:0] modelStep(op_e op, logic [7:0] data);
    logic [7:0] stb = '0;
    case (op)
      OP_ERR:    mMode = M_IDLE;
      OP_ADDR_W: mMode = M_PTR;
      OP_ADDR_R: mMode = M_RD;
      OP_RX: begin
        if (mMode == M_PTR) begin
          mPtr = int'(data);
          mMode = M_WR;
        end else if (mMode == M_WR) begin
          if (mPtr < NR && !RO[mPtr]) begin
            mRegs[mPtr] = data;
            stb[mPtr] = 1'b1;
          end
          mPtr = nextPtr(mPtr);
        end
      end
      default: if (mMode == M_RD) mPtr = nextPtr(mPtr);
    endcase
    return stb;
  endfunction

  task automatic resetChecks(input string tag);
    checkOutput({tag, " regs_out"}, regs_out, 64'h8000_6050_4030_2010);
    checkOutput({tag, " ptr"}, {56'h0, ptr}, 64'h0);
    checkOutput({tag, " wr_stb"}, {56'h0, reg_wr_stb}, 64'h0);
    checkOutput({tag, " tx"}, {56'h0, i2c_data_tx}, 64'h10);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    i2c_addr_rw = 8'h00;
    i2c_addr_rw_valid_stb = 1'b0;
    i2c_data_rx = 8'h00;
    i2c_data_rx_valid_stb = 1'b0;
    i2c_data_tx_loaded_stb = 1'b0;
    i2c_error_stb = 1'b0;
    regs_in = 64'hDE3C_BEEF_CAFE_F00D;

    addVec(OP_ADDR_W, 8'h00, 8'h00, 8'h00, 8'h10);
    addVec(OP_RX,     8'h02, 8'h02, 8'h00, 8'h30);
    addVec(OP_RX,     8'hA5, 8'h03, 8'h04, 8'h40);
    addVec(OP_RX,     8'h5A, 8'h04, 8'h08, 8'h50);
    addVec(OP_ERR,    8'h00, 8'h04, 8'h00, 8'h50);
    addVec(OP_ADDR_W, 8'h00, 8'h04, 8'h00, 8'h50);
    addVec(OP_RX,     8'h07, 8'h07, 8'h00, 8'h80);
    addVec(OP_RX,     8'h11, 8'h00, 8'h80, 8'h10);
    addVec(OP_RX,     8'h22, 8'h01, 8'h01, 8'h20);
    addVec(OP_ADDR_W, 8'h00, 8'h01, 8'h00, 8'h20);
    addVec(OP_RX,     8'h06, 8'h06, 8'h00, 8'h3C);
    addVec(OP_RX,     8'hFF, 8'h07, 8'h00, 8'h11);
    addVec(OP_ADDR_W, 8'h00, 8'h07, 8'h00, 8'h11);
    addVec(OP_RX,     8'h06, 8'h06, 8'h00, 8'h3C);
    addVec(OP_ADDR_R, 8'h00, 8'h06, 8'h00, 8'h3C);
    addVec(OP_TXL,    8'h00, 8'h07, 8'h00, 8'h11);
    addVec(OP_ADDR_W, 8'h00, 8'h07, 8'h00, 8'h11);
    addVec(OP_RX,     8'h09, 8'h09, 8'h00, 8'hFF);
    addVec(OP_ADDR_R, 8'h00, 8'h09, 8'h00, 8'hFF);
    addVec(OP_TXL,    8'h00, 8'h09, 8'h00, 8'hFF);
    addVec(OP_TXL,    8'h00, 8'h09, 8'h00, 8'hFF);
    addVec(OP_RX,     8'h55, 8'h09, 8'h00, 8'hFF);
    addVec(OP_ADDR_W, 8'h00, 8'h09, 8'h00, 8'hFF);
    addVec(OP_RX,     8'h05, 8'h05, 8'h00, 8'h60);
    addVec(OP_ADDR_R, 8'h00, 8'h05, 8'h00, 8'h60);
    addVec(OP_TXL,    8'h00, 8'h06, 8'h00, 8'h3C);
    addVec(OP_TXL,    8'h00, 8'h07, 8'h00, 8'h11);
    addVec(OP_TXL,    8'h00, 8'h00, 8'h00, 8'h22);
    addVec(OP_ERR,    8'h00, 8'h00, 8'h00, 8'h22);
    addVec(OP_TXL,    8'h00, 8'h00, 8'h00, 8'h22);
    addVec(OP_ADDR_W, 8'h00, 8'h00, 8'h00, 8'h22);
    addVec(OP_ERR,    8'h00, 8'h00, 8'h00, 8'h22);
    addVec(OP_ADDR_W, 8'h00, 8'h00, 8'h00, 8'h22);
    addVec(OP_TXL,    8'h00, 8'h00, 8'h00, 8'h22);
    addVec(OP_RX,     8'h03, 8'h03, 8'h00, 8'h5A);
    addVec(OP_TXL,    8'h00, 8'h03, 8'h00, 8'h5A);
    addVec(OP_RX,     8'h99, 8'h04, 8'h08, 8'h50);
    addVec(OP_ERR,    8'h00, 8'h04, 8'h00, 8'h50);
    addVec(OP_RX,     8'h77, 8'h04, 8'h00, 8'h50);

    repeat (3) @(posedge clk);
    #1;
    resetChecks("reset");
    rst = 1'b0;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].op, vecs[k].data);
      checkOutput($sformatf("vec%0d ptr", k), {56'h0, ptr}, {56'h0, vecs[k].expPtr});
      checkOutput($sformatf("vec%0d wr_stb", k), {56'h0, reg_wr_stb}, {56'h0, vecs[k].expStb});
      idleCycle();
      checkOutput($sformatf("vec%0d tx", k), {56'h0, i2c_data_tx}, {56'h0, vecs[k].expTx});
      checkOutput($sformatf("vec%0d stb_clear", k), {56'h0, reg_wr_stb}, 64'h0);
    end
    checkOutput("table regs_out", regs_out, 64'h1100_6050_99A5_2022);

    // New write address in the same cycle as a data byte: data is dropped, pointer byte expected next.
    applyStimulus(OP_ADDR_W, 8'h00);
    applyStimulus(OP_RX, 8'h01);
    i2c_data_rx = 8'hEE;
    i2c_data_rx_valid_stb = 1'b1;
    applyStimulus(OP_ADDR_W, 8'h00);
    checkOutput("prio ptr", {56'h0, ptr}, 64'h01);
    checkOutput("prio wr_stb", {56'h0, reg_wr_stb}, 64'h0);
    applyStimulus(OP_RX, 8'h02);
    checkOutput("prio ptr reload", {56'h0, ptr}, 64'h02);
    checkOutput("prio regs_out", regs_out, 64'h1100_6050_99A5_2022);

    // Reset arriving together with a data byte loses the write.
    applyStimulus(OP_ADDR_W, 8'h00);
    applyStimulus(OP_RX, 8'h01);
    rst = 1'b1;
    applyStimulus(OP_RX, 8'h5E);
    rst = 1'b0;
    resetChecks("rst_wr");

    // Reset in the middle of a read burst.
    applyStimulus(OP_ADDR_W, 8'h00);
    applyStimulus(OP_RX, 8'h03);
    applyStimulus(OP_RX, 8'hC4);
    applyStimulus(OP_ADDR_R, 8'h00);
    applyStimulus(OP_TXL, 8'h00);
    checkOutput("rd ptr before rst", {56'h0, ptr}, 64'h05);
    rst = 1'b1;
    idleCycle();
    rst = 1'b0;
    resetChecks("rst_rd");
    applyStimulus(OP_RX, 8'h33);
    checkOutput("post-rst idle rx ptr", {56'h0, ptr}, 64'h0);
    idleCycle();

    for (int i = 0; i < NR; i++) mRegs[i] = RO[i] ? 8'h00 : RV[i*8 +: 8];
    mPtr = 0;
    mMode = M_IDLE;
    for (int n = 0; n < 400; n++) begin
      op_e op;
      logic [7:0] d;
      logic [7:0] expStb;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 9:       op = OP_ADDR_W;
        1:          op = OP_ADDR_R;
        2, 3, 4, 5: op = OP_RX;
        6, 7:       op = OP_TXL;
        default:    op = OP_ERR;
      endcase
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 10));
      regs_in = {$urandom, $urandom};
      applyStimulus(op, d);
      expStb = modelStep(op, d);
      checkOutput($sformatf("rand%0d ptr", n), {56'h0, ptr}, 64'(mPtr));
      checkOutput($sformatf("rand%0d wr_stb", n), {56'h0, reg_wr_stb}, {56'h0, expStb});
      checkOutput($sformatf("rand%0d regs_out", n), regs_out, modelRegsOut());
      idleCycle();
      checkOutput($sformatf("rand%0d tx", n), {56'h0, i2c_data_tx}, {56'h0, modelRead()});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
